intersection_controller: RTL and testbench
==========================================

Name: intersection_controller

Overview:
- Parameterised multi-approach traffic signal controller; successor to the single-approach traffic light.
- Serves NUM_DIR approaches in round-robin: GREEN, YELLOW, then an ALL_RED clearance per approach.
- Adds latched pedestrian walk requests and a safe-entry flashing-red mode.
- Sits in the signal top level; outputs drive lamp drivers directly and are registered.

Parameters:
NUM_DIR, 2, number of approaches (2..8)
GREEN, 10, green duration in clk cycles (>= WALK+1)
YELLOW, 3, yellow duration in clk cycles (>= 1)
ALL_RED, 2, all-red clearance in clk cycles (>= 1)
WALK, 5, walk-lamp duration at start of a served green (>= 1)
FLASH_PERIOD, 2, flashing-red period in cycles (even, >= 2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
ped_req  in  NUM_DIR  pedestrian request pulse or level per approach
flash_en  in  1  request flashing-red mode
red  out  NUM_DIR  red lamp per approach
yellow  out  NUM_DIR  yellow lamp per approach
green  out  NUM_DIR  green lamp per approach
walk  out  NUM_DIR  walk lamp per approach
phase  out  $clog2(NUM_DIR)  approach currently or last served
flashing  out  1  high while in FLASH state

Behaviour:
- Reset (async assert) state:
  - state = ALL_RED; timer loaded with ALL_RED; phase = NUM_DIR-1.
  - red all ones; green, yellow, walk and flashing all zero; ped_pend all zero.
- State durations: each timed state lasts exactly its parameter count of rising clk edges. Timer is a down-counter; it reloads on state entry, and the transition occurs on the edge where it reaches 1.
- After rst release, all red holds for ALL_RED cycles, then green[0] asserts.
- Sequence: ALL_RED -> GREEN(phase+1 mod NUM_DIR) -> YELLOW -> ALL_RED -> ...
  - phase updates on GREEN entry.
  - Wrap from NUM_DIR-1 to 0.
- Lamp encoding outside FLASH:
  - red[d] = ~(green[d] | yellow[d]).
  - At most one bit of green|yellow is set.
  - green and yellow are never both set for the same approach.
- Pedestrian handling:
  - Any cycle with ped_req[d]=1 sets ped_pend[d].
  - On the GREEN-entry edge for approach d, if ped_pend[d] (including a request in that same cycle), clear ped_pend[d] and assert walk[d] for the first WALK cycles of green.
  - A request arriving after the GREEN-entry edge stays pending until d's next green.
  - walk is never asserted outside green[d].
- Flash mode:
  - flash_en is sampled only on the final ALL_RED cycle. If 1, enter FLASH instead of GREEN; phase is unchanged.
  - A green in progress is never truncated.
  - In FLASH: green, yellow and walk are 0; flashing = 1.
  - red = all ones for FLASH_PERIOD/2 cycles, then all zeros for FLASH_PERIOD/2 cycles, repeating; the first half-period is on.
  - ped_pend keeps accumulating while in FLASH.
  - Exit: flash_en = 0 sampled in any FLASH cycle -> ALL_RED (solid red, full ALL_RED cycles) -> GREEN(phase+1).
- Reset mid-operation: immediate return to the reset state regardless of current state; pending requests are discarded.
- Timer width: $clog2 of the maximum parameter + 1.
- Illegal parameters (GREEN <= WALK, odd FLASH_PERIOD) are flagged by an elaboration-time $error.

Decomposition:
- Shared package traffic_pkg:
  - state enum typedef: ALL_RED, GREEN, YELLOW, FLASH.
  - Timer-width helper function.
  - Default duration constants.
- One sub-module, phase_timer: loadable down-counter with load value, load strobe and done output. It is reused for state timing and for the flash half-period counter.

Test Plan (NUM_DIR=3, GREEN=12, YELLOW=4, ALL_RED=2, WALK=6, FLASH_PERIOD=2, clk period 1):
- Reset, release at t=5 -> red=3'b111 for 2 cycles; green[0] for 12 cycles; yellow[0] for 4 cycles; 2 all-red cycles; green[1]. Full rotation = 54 cycles; phase sequence 0, 1, 2, 0.
- ped_req[2] pulse during green[0] -> walk[2] high for the first 6 cycles of green[2] only; no walk on green[2] in the following rotation.
- ped_req[1] pulse on the GREEN-entry edge of approach 1 -> walk[1] served in that same green.
- ped_req[1] pulse 1 cycle after green[1] entry -> no walk this green; walk[1] on the next green[1].
- flash_en raised mid green[1] -> green[1] completes 12 cycles, yellow 4, all-red 2, then FLASH.
  - red toggles 111/000 every cycle; flashing = 1.
  - flash_en drop -> 2 solid-red cycles, then green[2].
- rst asserted mid yellow[2] -> outputs return to the reset state asynchronously (before the next edge); sequence restarts at green[0] after 2 red cycles. A check on every cycle asserts the lamp-exclusivity invariants.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types, default durations and width helpers for the intersection controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    StAllRed,
    StGreen,
    StYellow,
    StFlash
  } state_e;

  localparam int unsigned DefNumDir      = 2;
  localparam int unsigned DefGreen       = 10;
  localparam int unsigned DefYellow      = 3;
  localparam int unsigned DefAllRed      = 2;
  localparam int unsigned DefWalk        = 5;
  localparam int unsigned DefFlashPeriod = 2;

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned timer_width(input int unsigned max_val);
    return $clog2(max_val) + 1;
  endfunction

  function automatic int unsigned phase_width(input int unsigned num_dir);
    return (num_dir > 1) ? $clog2(num_dir) : 1;
  endfunction

endpackage

// File: rtl/intersection_controller_if.sv
// Request inputs and lamp outputs of the intersection controller.
interface intersection_controller_if #(
  parameter int unsigned NUM_DIR = traffic_pkg::DefNumDir
);
  localparam int unsigned PhW = traffic_pkg::phase_width(NUM_DIR);

  logic [NUM_DIR-1:0] ped_req;
  logic               flash_en;
  logic [NUM_DIR-1:0] red;
  logic [NUM_DIR-1:0] yellow;
  logic [NUM_DIR-1:0] green;
  logic [NUM_DIR-1:0] walk;
  logic [PhW-1:0]     phase;
  logic               flashing;

  modport master (
    output ped_req, flash_en,
    input  red, yellow, green, walk, phase, flashing
  );

  modport slave (
    input  ped_req, flash_en,
    output red, yellow, green, walk, phase, flashing
  );

endinterface

// File: rtl/phase_timer.sv
// Loadable down-counter; done is high while the count sits at 1, and it holds at 0.
module phase_timer #(
  parameter int unsigned      Width    = 4,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic [Width-1:0] count,
  output logic             done
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= ResetVal;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign done  = (count_q == Width'(1));

endmodule

// File: rtl/intersection_controller.sv
// Round-robin multi-approach signal controller with latched walk requests and flashing-red mode.
module intersection_controller
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_DIR      = DefNumDir,
  parameter int unsigned GREEN        = DefGreen,
  parameter int unsigned YELLOW       = DefYellow,
  parameter int unsigned ALL_RED      = DefAllRed,
  parameter int unsigned WALK         = DefWalk,
  parameter int unsigned FLASH_PERIOD = DefFlashPeriod
) (
  input logic                      clk,
  input logic                      rst,
  intersection_controller_if.slave bus
);

  localparam int unsigned PhW  = phase_width(NUM_DIR);
  localparam int unsigned Half = FLASH_PERIOD / 2;
  localparam int unsigned TW   = timer_width(max_of(max_of(GREEN, YELLOW), max_of(ALL_RED, Half)));

  localparam logic [PhW-1:0] LastPhase = PhW'(NUM_DIR - 1);
  localparam logic [TW-1:0]  TGreen    = TW'(GREEN);
  localparam logic [TW-1:0]  TYellow   = TW'(YELLOW);
  localparam logic [TW-1:0]  TAllRed   = TW'(ALL_RED);
  localparam logic [TW-1:0]  THalf     = TW'(Half);
  // Green-timer value during the last walk cycle.
  localparam logic [TW-1:0]  TWalkEnd  = TW'(GREEN - WALK + 1);

  if (GREEN <= WALK) begin : g_bad_walk
    $error("intersection_controller: GREEN must be greater than WALK");
  end
  if (FLASH_PERIOD < 2 || (FLASH_PERIOD % 2) != 0) begin : g_bad_flash
    $error("intersection_controller: FLASH_PERIOD must be even and at least 2");
  end

  state_e             state_q, state_d;
  logic [PhW-1:0]     phase_q, phase_d;
  logic [NUM_DIR-1:0] pend_q, pend_d;
  logic [NUM_DIR-1:0] walk_q, walk_d;
  logic [NUM_DIR-1:0] red_q, red_d;
  logic [NUM_DIR-1:0] yellow_q, yellow_d;
  logic [NUM_DIR-1:0] green_q, green_d;
  logic               flash_on_q, flash_on_d;
  logic               flashing_q, flashing_d;

  logic               timer_load, timer_done;
  logic [TW-1:0]      timer_val, timer_cnt;
  logic               ftimer_load, ftimer_done;
  logic [TW-1:0]      ftimer_cnt;

  phase_timer #(
    .Width   (TW),
    .ResetVal(TAllRed)
  ) u_state_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .load_val(timer_val),
    .count   (timer_cnt),
    .done    (timer_done)
  );

  phase_timer #(
    .Width   (TW),
    .ResetVal(THalf)
  ) u_flash_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (ftimer_load),
    .load_val(THalf),
    .count   (ftimer_cnt),
    .done    (ftimer_done)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    pend_d      = pend_q | bus.ped_req;
    walk_d      = walk_q;
    flash_on_d  = flash_on_q;
    timer_load  = 1'b0;
    timer_val   = TAllRed;
    ftimer_load = 1'b0;

    unique case (state_q)
      StAllRed: begin
        if (timer_done) begin
          timer_load = 1'b1;
          if (bus.flash_en) begin
            state_d     = StFlash;
            flash_on_d  = 1'b1;
            ftimer_load = 1'b1;
          end else begin
            state_d   = StGreen;
            timer_val = TGreen;
            phase_d   = (phase_q == LastPhase) ? '0 : phase_q + 1'b1;
            walk_d    = '0;
            if (pend_d[phase_d]) begin
              walk_d[phase_d] = 1'b1;
              pend_d[phase_d] = 1'b0;
            end
          end
        end
      end
      StGreen: begin
        if (timer_done) begin
          state_d    = StYellow;
          timer_load = 1'b1;
          timer_val  = TYellow;
          walk_d     = '0;
        end else if (timer_cnt == TWalkEnd) begin
          walk_d = '0;
        end
      end
      StYellow: begin
        if (timer_done) begin
          state_d    = StAllRed;
          timer_load = 1'b1;
        end
      end
      StFlash: begin
        if (!bus.flash_en) begin
          state_d    = StAllRed;
          timer_load = 1'b1;
        end else if (ftimer_done || ftimer_cnt == '0) begin
          // An idle (zero) half-period timer is re-armed rather than stalling the blink.
          flash_on_d  = ~flash_on_q;
          ftimer_load = 1'b1;
        end
      end
      default: state_d = StAllRed;
    endcase
  end

  // Lamps are decoded from the next state so the registered outputs line up with state_q.
  always_comb begin
    green_d    = '0;
    yellow_d   = '0;
    red_d      = '1;
    flashing_d = 1'b0;
    unique case (state_d)
      StGreen: begin
        green_d[phase_d] = 1'b1;
        red_d[phase_d]   = 1'b0;
      end
      StYellow: begin
        yellow_d[phase_d] = 1'b1;
        red_d[phase_d]    = 1'b0;
      end
      StFlash: begin
        flashing_d = 1'b1;
        red_d      = {NUM_DIR{flash_on_d}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StAllRed;
      phase_q    <= LastPhase;
      pend_q     <= '0;
      walk_q     <= '0;
      flash_on_q <= 1'b0;
      red_q      <= '1;
      yellow_q   <= '0;
      green_q    <= '0;
      flashing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      pend_q     <= pend_d;
      walk_q     <= walk_d;
      flash_on_q <= flash_on_d;
      red_q      <= red_d;
      yellow_q   <= yellow_d;
      green_q    <= green_d;
      flashing_q <= flashing_d;
    end
  end

  assign bus.red      = red_q;
  assign bus.yellow   = yellow_q;
  assign bus.green    = green_q;
  assign bus.walk     = walk_q;
  assign bus.phase    = phase_q;
  assign bus.flashing = flashing_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Directed walk/flash/reset scenario followed by randomized traffic, checked against a cycle model.
module tb_intersection_controller;

  localparam int unsigned NumDir      = 3;
  localparam int unsigned Green       = 12;
  localparam int unsigned Yellow      = 4;
  localparam int unsigned AllRed      = 2;
  localparam int unsigned Walk        = 6;
  localparam int unsigned FlashPeriod = 2;

  localparam int ModeRed    = 0;
  localparam int ModeGreen  = 1;
  localparam int ModeYellow = 2;
  localparam int ModeFlash  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  intersection_controller_if #(.NUM_DIR(NumDir)) bus ();

  intersection_controller #(
    .NUM_DIR     (NumDir),
    .GREEN       (Green),
    .YELLOW      (Yellow),
    .ALL_RED     (AllRed),
    .WALK        (Walk),
    .FLASH_PERIOD(FlashPeriod)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: elapsed cycles in the current interval, counted upward.
  int              m_mode;
  int              m_elapsed;
  int              m_phase;
  int              m_walk_left;
  int              m_flash_cycles;
  bit [NumDir-1:0] m_pend;

  task automatic model_reset();
    m_mode         = ModeRed;
    m_elapsed      = 0;
    m_phase        = NumDir - 1;
    m_walk_left    = 0;
    m_flash_cycles = 0;
    m_pend         = '0;
  endtask

  task automatic model_step(input bit [NumDir-1:0] req, input bit fe);
    m_pend |= req;
    case (m_mode)
      ModeRed: begin
        m_elapsed++;
        if (m_elapsed == AllRed) begin
          m_elapsed = 0;
          if (fe) begin
            m_mode         = ModeFlash;
            m_flash_cycles = 0;
          end else begin
            m_mode              = ModeGreen;
            m_phase             = (m_phase + 1) % NumDir;
            m_walk_left         = m_pend[m_phase] ? Walk : 0;
            m_pend[m_phase]     = 1'b0;
          end
        end
      end
      ModeGreen: begin
        m_elapsed++;
        if (m_walk_left > 0) m_walk_left--;
        if (m_elapsed == Green) begin
          m_mode    = ModeYellow;
          m_elapsed = 0;
        end
      end
      ModeYellow: begin
        m_elapsed++;
        if (m_elapsed == Yellow) begin
          m_mode    = ModeRed;
          m_elapsed = 0;
        end
      end
      default: begin
        if (!fe) begin
          m_mode    = ModeRed;
          m_elapsed = 0;
        end else begin
          m_flash_cycles++;
        end
      end
    endcase
  endtask

  task automatic check_outputs();
    bit [NumDir-1:0] eg, ey, er, ew;
    eg = '0;
    ey = '0;
    ew = '0;
    if (m_mode == ModeGreen) eg[m_phase] = 1'b1;
    if (m_mode == ModeYellow) ey[m_phase] = 1'b1;
    if (m_mode == ModeGreen && m_walk_left > 0) ew[m_phase] = 1'b1;
    er = ~(eg | ey);
    if (m_mode == ModeFlash) er = (((m_flash_cycles / (FlashPeriod / 2)) % 2) == 0) ? '1 : '0;
    check_eq("red", bus.red, er);
    check_eq("yellow", bus.yellow, ey);
    check_eq("green", bus.green, eg);
    check_eq("walk", bus.walk, ew);
    check_eq("phase", bus.phase, m_phase);
    check_eq("flashing", bus.flashing, m_mode == ModeFlash);
    check_eq("lamp_excl", $countones(bus.green | bus.yellow) <= 1, 1);
    check_eq("walk_in_green", (bus.walk & ~bus.green) == '0, 1);
  endtask

  task automatic run_cycle(input bit [NumDir-1:0] req, input bit fe);
    @(negedge clk);
    bus.ped_req  = req;
    bus.flash_en = fe;
    @(posedge clk);
    if (!rst) model_step(req, fe);
    #1 check_outputs();
  endtask

  // Reset is raised between edges so the outputs must clear without a clock.
  task automatic pulse_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    model_reset();
    #1 check_outputs();
    @(posedge clk);
    #1 check_outputs();
    #2 rst = 1'b0;
  endtask

  initial begin
    bit [NumDir-1:0] req;
    bit              fe;
    int              fe_left;

    bus.ped_req  = '0;
    bus.flash_en = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    #2 check_outputs();
    @(posedge clk);
    #1 check_outputs();
    #2 rst = 1'b0;

    // Directed: walk request latencies, flash entry mid green[1], reset during yellow[2].
    for (int i = 1; i <= 135; i++) begin
      req = '0;
      if (i == 5) req = 3'b100;
      if (i == 20 || i == 75) req = 3'b010;
      fe = (i >= 80 && i < 120);
      run_cycle(req, fe);
    end
    pulse_reset();
    for (int i = 0; i < 60; i++) run_cycle('0, 1'b0);

    // Randomized traffic with flash episodes and occasional resets.
    fe      = 1'b0;
    fe_left = $urandom_range(50, 200);
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < NumDir; d++) req[d] = ($urandom_range(0, 7) == 0);
      if (fe_left == 0) begin
        fe      = ~fe;
        fe_left = fe ? $urandom_range(1, 60) : $urandom_range(30, 200);
      end else begin
        fe_left--;
      end
      run_cycle(req, fe);
      if ($urandom_range(0, 599) == 0) pulse_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
